// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_LOW     = 2'd1,
    ST_HIGH    = 2'd2
  } ch_state_e;

  localparam int MIN_DIV = 32'sd2;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 32'sd0;
    v   = value - 32'sd1;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 1;
    end
    return res;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (clog2(num_ch) < 32'sd1) ? 32'sd1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: state machine, period counter and pending divisor.
// The sync input exists only when CLKDIV_SYNC_EN is defined.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
    return (d == DIV_W'(1)) ? DIV_W'(MIN_DIV) : d;
  endfunction

  localparam logic [DIV_W-1:0] RST_DIV   = norm_div(DIV_W'(RESET_DIV));
  localparam ch_state_e        RST_STATE = (RESET_DIV == 0) ? ST_STOPPED : ST_LOW;

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_flag_q, pend_flag_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] hi_len_s, lo_len_s, new_div_s, next_div_s;
  logic             boundary_s, queue_wr_s;

  // Phase lengths; an odd divisor gets the extra cycle in the low phase.
  always_comb begin
    hi_len_s   = act_div_q >> 1;
    lo_len_s   = act_div_q - hi_len_s;
    new_div_s  = norm_div(wr_div);
    next_div_s = pend_flag_q ? pend_div_q : act_div_q;
    boundary_s = (state_q == ST_HIGH) && (cnt_q == hi_len_s - DIV_W'(1));
    queue_wr_s = wr_en && (state_q != ST_STOPPED);
  end

  // Next-state, counter and divisor update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_div_d   = act_div_q;
    pend_div_d  = pend_div_q;
    pend_flag_d = pend_flag_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
`ifdef CLKDIV_SYNC_EN
    if (sync) begin
      // A write landing on the sync edge joins the realignment directly.
      act_div_d   = wr_en ? new_div_s : next_div_s;
      pend_flag_d = 1'b0;
      cnt_d       = '0;
      clk_out_d   = 1'b0;
      state_d     = ((wr_en ? new_div_s : next_div_s) == '0) ? ST_STOPPED : ST_LOW;
    end else begin
`endif
      case (state_q)
        ST_STOPPED: begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          if (wr_en) begin
            act_div_d = new_div_s;
            state_d   = (new_div_s == '0) ? ST_STOPPED : ST_LOW;
          end else begin
            state_d   = ST_STOPPED;
          end
        end
        ST_LOW: begin
          if (cnt_q == lo_len_s - DIV_W'(1)) begin
            state_d   = ST_HIGH;
            cnt_d     = '0;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
          end else begin
            cnt_d     = cnt_q + DIV_W'(1);
          end
        end
        ST_HIGH: begin
          if (boundary_s) begin
            act_div_d = next_div_s;
            cnt_d     = '0;
            clk_out_d = 1'b0;
            state_d   = (next_div_s == '0) ? ST_STOPPED : ST_LOW;
          end else begin
            cnt_d     = cnt_q + DIV_W'(1);
          end
        end
        default: begin
          state_d   = (act_div_q == '0) ? ST_STOPPED : ST_LOW;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end
      endcase
      // The boundary consumes the old pending value before a new write queues.
      pend_div_d  = queue_wr_s ? new_div_s : pend_div_q;
      pend_flag_d = queue_wr_s | (pend_flag_q & ~boundary_s);
`ifdef CLKDIV_SYNC_EN
    end
`endif
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      act_div_q   <= RST_DIV;
      pend_div_q  <= '0;
      pend_flag_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_div_q   <= act_div_d;
      pend_div_q  <= pend_div_d;
      pend_flag_q <= pend_flag_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

  assign pend_o = pend_flag_q;
  assign clk_o  = clk_out_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel runtime-programmable clock divider with glitch-free divisor updates.
// Defining CLKDIV_SYNC_EN adds the sync port for phase-aligning all channels.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  DIV_W     = 16,
  parameter int  RESET_DIV = 2,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] wr_en_s;

  // Out-of-range channel numbers select nothing, so they are always ready and dropped.
  assign wr_ready = ~|(pend_s & sel_s);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel_s[g]   = (wr_ch == CH_W'(g));
    assign wr_en_s[g] = wr_valid & wr_ready & sel_s[g];

    clkdiv_channel #(
      .DIV_W     (DIV_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en_s[g]),
      .wr_div (wr_div),
`ifdef CLKDIV_SYNC_EN
      .sync   (sync),
`endif
      .pend_o (pend_s[g]),
      .clk_o  (clk_out[g]),
      .tick_o (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: a phase-in-period reference model
// predicts clk_out/tick/wr_ready; monitors compare them against the DUT.
`timescale 1ns/1ps
module tb_clock_divider_prog;

  localparam int NUM_CH    = 3;
  localparam int DIV_W     = 16;
  localparam int RESET_DIV = 2;
  localparam int CH_W      = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic              sync_r;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  always #5 clk = ~clk;

  clock_divider_prog #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
`ifdef CLKDIV_SYNC_EN
    .sync     (sync_r),
`endif
    .clk_out  (clk_out),
    .tick     (tick)
  );

  typedef struct {
    logic [NUM_CH-1:0] clk_v;
    logic [NUM_CH-1:0] tick_v;
  } out_t;

  int   checks = 0;
  int   errors = 0;
  out_t out_q[$];
  bit   rdy_q[$];

  // Reference model: each channel tracks its divisor and the cycle index within the current period.
  int m_n   [NUM_CH];
  int m_ph  [NUM_CH];
  bit m_run [NUM_CH];
  bit m_pf  [NUM_CH];
  int m_pd  [NUM_CH];

  function automatic int eff(input int d);
    return (d == 1) ? 2 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_n[i]   = eff(RESET_DIV);
      m_ph[i]  = 0;
      m_run[i] = (m_n[i] != 0);
      m_pf[i]  = 1'b0;
      m_pd[i]  = 0;
    end
  endtask

  function automatic bit model_ready(input int ch);
    if (ch >= NUM_CH) return 1'b1;
    return !m_pf[ch];
  endfunction

  task automatic model_step(input bit acc, input int ch, input int d, input bit s);
    for (int i = 0; i < NUM_CH; i++) begin
      bit wr_here;
      wr_here = acc && (ch == i);
      if (s) begin
        if (wr_here) m_n[i] = eff(d);
        else if (m_pf[i]) m_n[i] = m_pd[i];
        m_pf[i]  = 1'b0;
        m_ph[i]  = 0;
        m_run[i] = (m_n[i] != 0);
      end else if (!m_run[i]) begin
        if (wr_here) begin
          m_n[i]   = eff(d);
          m_ph[i]  = 0;
          m_run[i] = (m_n[i] != 0);
        end
      end else begin
        m_ph[i] = m_ph[i] + 1;
        if (m_ph[i] == m_n[i]) begin
          if (m_pf[i]) begin
            m_n[i]  = m_pd[i];
            m_pf[i] = 1'b0;
          end
          m_ph[i]  = 0;
          m_run[i] = (m_n[i] != 0);
        end
        if (wr_here) begin
          m_pd[i] = eff(d);
          m_pf[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    int   lo;
    o.clk_v  = '0;
    o.tick_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_run[i]) begin
        lo          = m_n[i] - m_n[i] / 2;
        o.clk_v[i]  = (m_ph[i] >= lo);
        o.tick_v[i] = (m_ph[i] == lo);
      end
    end
    return o;
  endfunction

  // One clock of stimulus: drive at negedge, predict ready, advance model at posedge.
  task automatic cycle(input bit v, input int ch, input int d, input bit s, output bit acc);
    bit er;
    @(negedge clk);
    wr_valid = v;
    wr_ch    = CH_W'(ch);
    wr_div   = DIV_W'(d);
    sync_r   = s;
    er       = model_ready(ch);
    rdy_q.push_back(er);
    acc = v && er;
    @(posedge clk);
    model_step(acc, ch, d, s);
    out_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0, a);
  endtask

  task automatic write_until_accepted(input int ch, input int d, input int budget);
    bit a;
    a = 1'b0;
    for (int k = 0; k < budget && !a; k++) cycle(1'b1, ch, d, 1'b0, a);
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL accept_timeout ch=%0d div=%0d not accepted within %0d cycles", ch, d, budget);
    end
  endtask

  // Output monitor: compares clk_out/tick just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_q.size() > 0) begin
        out_t e;
        e = out_q.pop_front();
        checks++;
        if (clk_out !== e.clk_v || tick !== e.tick_v) begin
          errors++;
          $display("FAIL outputs t=%0t clk_out=%b tick=%b expected clk_out=%b tick=%b",
                   $time, clk_out, tick, e.clk_v, e.tick_v);
        end
      end
    end
  end

  // Handshake monitor: compares wr_ready once inputs have settled after the negedge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() > 0) begin
        bit e;
        e = rdy_q.pop_front();
        checks++;
        if (wr_ready !== e) begin
          errors++;
          $display("FAIL wr_ready t=%0t wr_ch=%0d got=%b expected=%b", $time, wr_ch, wr_ready, e);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (clk_out !== '0 || tick !== '0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s clk_out=%b tick=%b wr_ready=%b expected 0/0/1", tag, clk_out, tick, wr_ready);
    end
  endtask

  initial begin
    bit   a;
    bit   v;
    bit   s;
    bit   found;
    int   ch;
    int   d;
    out_t o;

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_div   = '0;
    sync_r   = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check_reset_outputs("reset_state");
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset divisor 2 on every channel, then ch1 reprogrammed to 5 mid-run.
    idle(10);
    cycle(1'b1, 1, 5, 1'b0, a);
    idle(20);

    // Stop ch0, then restart it with an odd divisor.
    cycle(1'b1, 0, 0, 1'b0, a);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      idle(1);
      found = !m_run[0];
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ch0_stop model never reached stop");
    end
    idle(3);
    cycle(1'b1, 0, 7, 1'b0, a);
    idle(20);

    // Back-to-back writes to ch2: the second one stalls until the boundary.
    cycle(1'b1, 2, 8, 1'b0, a);
    write_until_accepted(2, 3, 40);
    idle(30);

    // Divisor 1 acts as 2; an out-of-range channel is accepted and ignored.
    write_until_accepted(1, 1, 20);
    idle(15);
    cycle(1'b1, NUM_CH, 9, 1'b0, a);
    idle(8);

`ifdef CLKDIV_SYNC_EN
    write_until_accepted(0, 4, 20);
    idle(9);
    write_until_accepted(1, 4, 20);
    idle(13);
    cycle(1'b0, 0, 0, 1'b1, a);
    idle(12);
`endif

    for (int k = 0; k < 1500; k++) begin
      v  = ($urandom_range(0, 3) == 0);
      ch = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 1);
      else d = $urandom_range(2, 11);
      s = 1'b0;
`ifdef CLKDIV_SYNC_EN
      s = ($urandom_range(0, 49) == 0);
`endif
      cycle(v, ch, d, s, a);
    end

    // Asynchronous reset while at least one channel is high.
    write_until_accepted(0, 6, 30);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      idle(1);
      o = model_out();
      found = (o.clk_v != '0);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_setup no channel high before reset");
    end
    #3;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    sync_r   = 1'b0;
    wr_ch    = '0;
    #1;
    checks++;
    if (clk_out !== '0 || tick !== '0) begin
      errors++;
      $display("FAIL async_reset clk_out=%b tick=%b expected 0/0", clk_out, tick);
    end
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #2;
      check_reset_outputs("reset_hold");
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(12);

    #4;
    checks++;
    if (out_q.size() != 0 || rdy_q.size() != 0) begin
      errors++;
      $display("FAIL drain out_q=%0d rdy_q=%0d expected 0/0", out_q.size(), rdy_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
